// File: rtl/rx_word_assembler_pkg.sv
// Shared definitions for the RX word assembler: state encoding and the
// byte width used across the UART RX/TX path.
package rx_word_assembler_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_HOLD    = 1'b1;

    typedef enum logic {
        COLLECT = ST_COLLECT,
        HOLD    = ST_HOLD
    } state_t;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte silence counter: clears on i_clear or when not running, and
// flags the terminal count so the caller can discard a stale partial word.
module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // A clear in the terminal cycle suppresses expiry: a late byte still counts.
    assign o_expired = i_run && !i_clear && (cnt_q == TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (i_clear || !i_run || o_expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs consecutive UART RX bytes little-endian into one word and offers it
// on a valid/ready port. Optional inter-byte timeout: define RX_WORD_TIMEOUT_EN.
module rx_word_assembler
    import rx_word_assembler_pkg::*;
#(
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_rx_done,
    input  logic [DATA_BITS-1:0]               i_rx_data,
    output logic [WORD_BYTES*DATA_BITS-1:0]    o_word,
    output logic                               o_word_valid,
    input  logic                               i_word_ready,
    output logic [$clog2(WORD_BYTES+1)-1:0]    o_byte_count,
    output logic                               o_overrun,
    output logic                               o_timeout
);

    localparam int CNT_W = $clog2(WORD_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORD_BYTES - 1);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [CNT_W-1:0]                wr_lane;
    logic                            wr_en;
    logic                            overrun_d;
    logic                            tmo_hit;
    logic [WORD_BYTES*DATA_BITS-1:0] word_q;

    // Handshake: o_word is transferred on any clk edge where o_word_valid and
    // i_word_ready are both high; o_word/o_word_valid never change while valid
    // is waiting, and ready without valid has no effect.
    assign o_word_valid = (state_q == HOLD);
    assign o_word       = word_q;
    assign o_byte_count = count_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_lane   = count_q;
        overrun_d = o_overrun;
        case (state_q)
            COLLECT: begin
                if (i_rx_done) begin
                    wr_en = 1'b1;
                    if (count_q == LAST_LANE) begin
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    count_d = '0;
                end
            end
            HOLD: begin
                if (i_word_ready) begin
                    state_d = COLLECT;
                    if (i_rx_done) begin
                        wr_en   = 1'b1;
                        wr_lane = '0;
                        count_d = CNT_W'(1);
                    end
                end else if (i_rx_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            o_overrun <= 1'b0;
            word_q    <= '0;
        end else begin
            count_q   <= count_d;
            o_overrun <= overrun_d;
            if (wr_en) begin
                word_q[int'(wr_lane)*DATA_BITS +: DATA_BITS] <= i_rx_data;
            end
        end
    end

`ifdef RX_WORD_TIMEOUT_EN
    logic tmo_run;

    assign tmo_run = (state_q == COLLECT) && (count_q != '0);

    rx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (i_rx_done),
        .i_run     (tmo_run),
        .o_expired (tmo_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= tmo_hit;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed bench for rx_word_assembler: scoreboard queue of expected words
// checked by a monitor on every valid&ready transfer, plus direct state checks.
module tb_rx_word_assembler;

    localparam int DATA_BITS  = 8;
    localparam int WORD_BYTES = 4;
    localparam int W          = DATA_BITS * WORD_BYTES;
    localparam int CW         = $clog2(WORD_BYTES + 1);

    logic                 clk;
    logic                 rst;
    logic                 i_rx_done;
    logic [DATA_BITS-1:0] i_rx_data;
    logic [W-1:0]         o_word;
    logic                 o_word_valid;
    logic                 i_word_ready;
    logic [CW-1:0]        o_byte_count;
    logic                 o_overrun;
    logic                 o_timeout;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;
    int valid_cycles;
    int tmo_pulses;

    rx_word_assembler #(
        .DATA_BITS      (DATA_BITS),
        .WORD_BYTES     (WORD_BYTES),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_byte_count (o_byte_count),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks: all input changes happen 1ns after a rising edge
    task automatic send_byte(input logic [DATA_BITS-1:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge clk);
        #1;
        i_rx_done = 1'b0;
        i_rx_data = $urandom_range(0, 255);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check("reset_count", o_byte_count, 0);
        check("reset_valid", o_word_valid, 0);
        check("reset_overrun", o_overrun, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (o_word_valid) valid_cycles++;
            if (o_timeout) tmo_pulses++;
            if (o_word_valid && i_word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_word actual=%0h expected=none", o_word);
                end else begin
                    check("sb_word", o_word, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int v0;
        int t0;
        checks       = 0;
        failures     = 0;
        valid_cycles = 0;
        tmo_pulses   = 0;
        rst          = 1'b0;
        i_rx_done    = 1'b0;
        i_rx_data    = '0;
        i_word_ready = 1'b0;

        #12;
        check("por_count", o_byte_count, 0);
        check("por_valid", o_word_valid, 0);
        check("por_overrun", o_overrun, 0);
        check("por_timeout", o_timeout, 0);
        check("por_word", o_word, 0);
        rst = 1'b1;
        idle(1);

        // reset mid-word, then a fresh word
        send_byte(8'h11);
        send_byte(8'h22);
        check("midword_count", o_byte_count, 2);
        pulse_reset();
        i_word_ready = 1'b1;
        exp_q.push_back(32'h04030201);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("fresh_valid", o_word_valid, 1);
        idle(1);
        check("fresh_valid_drop", o_word_valid, 0);

        // basic assembly with ready held high
        v0 = valid_cycles;
        exp_q.push_back(32'hDEADBEEF);
        send_byte(8'hEF);
        check("basic_cnt1", o_byte_count, 1);
        send_byte(8'hBE);
        check("basic_cnt2", o_byte_count, 2);
        send_byte(8'hAD);
        check("basic_cnt3", o_byte_count, 3);
        check("basic_not_valid", o_word_valid, 0);
        send_byte(8'hDE);
        check("basic_valid", o_word_valid, 1);
        check("basic_cnt0", o_byte_count, 0);
        check("basic_word", o_word, 32'hDEADBEEF);
        idle(2);
        check("basic_valid_1cyc", valid_cycles - v0, 1);

        // backpressure and overrun
        i_word_ready = 1'b0;
        exp_q.push_back(32'h44332211);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("bp_valid", o_word_valid, 1);
        check("bp_no_overrun_yet", o_overrun, 0);
        send_byte(8'h55);
        check("bp_overrun", o_overrun, 1);
        check("bp_word_held", o_word, 32'h44332211);
        idle(3);
        check("bp_word_stable", o_word, 32'h44332211);
        check("bp_valid_stable", o_word_valid, 1);
        check("bp_overrun_sticky", o_overrun, 1);
        i_word_ready = 1'b1;
        idle(1);
        check("bp_valid_drop", o_word_valid, 0);
        check("bp_count0", o_byte_count, 0);
        check("bp_overrun_kept", o_overrun, 1);

        // simultaneous accept and new byte
        pulse_reset();
        i_word_ready = 1'b0;
        exp_q.push_back(32'h0D0C0B0A);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        send_byte(8'h0D);
        check("sim_valid", o_word_valid, 1);
        i_word_ready = 1'b1;
        send_byte(8'h77);
        check("sim_count1", o_byte_count, 1);
        check("sim_valid0", o_word_valid, 0);
        check("sim_lane0", o_word[7:0], 8'h77);
        check("sim_no_overrun", o_overrun, 0);
        exp_q.push_back(32'hCCBBAA77);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("sim_word_valid", o_word_valid, 1);
        idle(1);

        // inter-byte silence of 50 cycles
        t0 = tmo_pulses;
        send_byte(8'h01);
        send_byte(8'h02);
        idle(50);
`ifdef RX_WORD_TIMEOUT_EN
        check("tmo_pulse_now", o_timeout, 1);
        check("tmo_count0", o_byte_count, 0);
        idle(3);
        check("tmo_one_pulse", tmo_pulses - t0, 1);
        exp_q.push_back(32'hA3A2A1A0);
`else
        check("notmo_pulse", o_timeout, 0);
        check("notmo_count2", o_byte_count, 2);
        idle(3);
        check("notmo_no_pulses", tmo_pulses - t0, 0);
        exp_q.push_back(32'hA1A00201);
`endif
        send_byte(8'hA0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
`ifdef RX_WORD_TIMEOUT_EN
        check("tmo_word_valid", o_word_valid, 1);
        check("tmo_word", o_word, 32'hA3A2A1A0);
`else
        check("notmo_partial_cnt", o_byte_count, 2);
`endif
        idle(1);

        // byte arriving in the terminal idle cycle beats the timeout
        pulse_reset();
        t0 = tmo_pulses;
        send_byte(8'h5A);
        idle(49);
        send_byte(8'h5B);
        check("edge_count2", o_byte_count, 2);
        idle(2);
        check("edge_no_pulse", tmo_pulses - t0, 0);
        exp_q.push_back(32'h5D5C5B5A);
        send_byte(8'h5C);
        send_byte(8'h5D);
        check("edge_word", o_word, 32'h5D5C5B5A);
        idle(1);

        // drain: every expected word must have been seen
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Downstream consumer of the UART RX stage.
- Gathers consecutive received bytes (rx_done/data pulses) into one WORD_BYTES-wide word and presents it on a valid/ready handshake to the loader/debug unit.
- Single-entry hold register, overrun detection, optional inter-byte timeout that discards stale partial words.

Parameters:
- DATA_BITS, 8, width of one received byte; matches RX o_data width.
- WORD_BYTES, 4, bytes per assembled word (≥2).
- TIMEOUT_CYCLES, 100000, clk cycles of inter-byte silence before a partial word is discarded (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- i_rx_done  input  1  single-cycle strobe from RX: i_rx_data valid this cycle.
- i_rx_data  input  DATA_BITS  received byte.
- o_word  output  WORD_BYTES*DATA_BITS  assembled word, first received byte in bits [DATA_BITS-1:0] (little-endian).
- o_word_valid  output  1  o_word holds a complete word.
- i_word_ready  input  1  consumer accepts o_word when high with o_word_valid.
- o_byte_count  output  clog2(WORD_BYTES+1)  bytes stored in current partial word.
- o_overrun  output  1  sticky: a byte was dropped because the hold register was full.
- o_timeout  output  1  one-cycle pulse: partial word discarded on timeout.

Behaviour:
- Reset (rst low, async): all outputs 0; state COLLECT; timeout counter 0; shift/assembly register 0.
- States: COLLECT (accumulating), HOLD (complete word waiting on consumer).
- COLLECT: on i_rx_done, byte written to lane o_byte_count; count increments at the same edge.
- Last lane written: the next cycle shows o_word_valid=1, o_byte_count=0, state HOLD. Latency from final rx_done to valid is 1 clk.
- HOLD: o_word and o_word_valid stay stable until i_word_ready=1. The transfer occurs on the edge with valid&ready. Valid drops the next cycle and state returns to COLLECT.
- HOLD with i_rx_done and no ready in the same cycle: byte dropped, o_overrun set. o_overrun clears only on reset.
- HOLD with i_rx_done and ready in the same cycle: word transferred and the new byte stored in lane 0. The next cycle shows count=1, valid=0, no overrun.
- o_word lanes not yet written in a new word keep stale data. The consumer uses o_word only when valid.
- i_word_ready while not valid: ignored.
- i_rx_data sampled only when i_rx_done=1.

Optional Feature:
- Macro: RX_WORD_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT while o_byte_count>0. It resets to 0 on every i_rx_done.
  - When the counter reaches TIMEOUT_CYCLES-1 without a byte: count forced to 0, o_timeout pulses 1 cycle, counter cleared.
  - i_rx_done in that same cycle wins: byte stored, no timeout.
  - Counter idle in HOLD and when count=0.
- Undefined: no counter logic; o_timeout tied 0; port list unchanged.

Decomposition:
- Shared package holds:
  - localparams for state encoding (COLLECT, HOLD);
  - the DATA_BITS default of 8, shared with RX and TX.
- One natural sub-module: rx_timeout_counter, the load/clear/terminal-count counter, instantiated only under RX_WORD_TIMEOUT_EN.
- Assembly/handshake logic stays in the top module.

Test Plan:
- Reset mid-word: send 0x11, 0x22, assert rst low → count=0, valid=0, o_overrun=0 immediately. Then 4 fresh bytes give a correct word.
- Basic assembly: bytes 0xEF, 0xBE, 0xAD, 0xDE with ready=1 →
  - o_word=0xDEADBEEF, valid for exactly 1 cycle, one clk after the 4th rx_done;
  - o_byte_count steps 1, 2, 3, 0.
- Backpressure/overrun: ready=0, send 4 bytes then a 5th byte 0x55 →
  - word held stable and unchanged;
  - o_overrun=1 stays set;
  - after ready=1, valid drops and count=0.
- Simultaneous accept and byte: in HOLD, assert ready and rx_done(0x77) on the same cycle → transfer happens; next cycle count=1, lane0=0x77, o_overrun=0.
- Timeout (macro defined, TIMEOUT_CYCLES=50): send 0x01, 0x02, idle 50 cycles → o_timeout pulses once, count=0. Then 0xA0, 0xA1, 0xA2, 0xA3 → o_word=0xA3A2A1A0.
- Timeout boundary: byte arrives on cycle 49 of idle → no o_timeout, count advances.
- Macro undefined: same idle stimulus → no o_timeout, count stays 2.
